// File: rtl/arm_alu_seq.sv
// Registered ARM data-processing ALU with condition gating, an NZCV flag register
// and a shift-and-add MUL/MLA unit behind a valid/ready handshake.
module arm_alu_seq #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic                 in_mul,
  input  logic                 in_acc,
  input  logic                 in_set_flags,
  input  logic [3:0]           in_cond,
  input  logic [DATAWIDTH-1:0] in_a,
  input  logic [DATAWIDTH-1:0] in_b,
  input  logic [DATAWIDTH-1:0] in_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_result,
  output logic                 out_wr,
  output logic                 out_executed,
  output logic [3:0]           flags_nzcv
);

  localparam int CW = $clog2(DATAWIDTH + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state, state_next;
  logic [3:0]           flags;
  logic [DATAWIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0]        cnt;
  logic                 mul_s;

  logic                 accept, cond_pass, is_test, arith, cin, mul_done, mul_full;
  logic [DATAWIDTH-1:0] op_x, op_y, alu_res;
  logic [DATAWIDTH:0]   sum;
  logic                 alu_c, alu_v;
  logic                 fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flags;
  assign flags_nzcv = flags;
  assign in_ready   = (state == IDLE) & (~out_valid | out_ready);
  assign accept     = in_valid & in_ready;
  assign is_test    = (in_op[3:2] == 2'b10);
  assign mul_full   = (cnt == CW'(DATAWIDTH));
  assign mul_done   = (state == MUL) & mul_full & (~out_valid | out_ready);

  always_comb begin
    cond_pass = 1'b1;
    case (in_cond)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = ~fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = ~fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = ~fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = ~fv;
      4'h8: cond_pass = fc & ~fz;
      4'h9: cond_pass = ~fc | fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = ~fz & (fn == fv);
      4'hD: cond_pass = fz | (fn != fv);
      default: cond_pass = 1'b1;
    endcase
  end

  // Every arithmetic opcode is one adder: x + y + cin with operands swapped/inverted.
  always_comb begin
    op_x  = '0;
    op_y  = '0;
    cin   = 1'b0;
    arith = 1'b1;
    case (in_op)
      4'b0010, 4'b1010: begin op_x = in_a; op_y = ~in_b; cin = 1'b1; end
      4'b0011:          begin op_x = in_b; op_y = ~in_a; cin = 1'b1; end
      4'b0100, 4'b1011: begin op_x = in_a; op_y = in_b;  cin = 1'b0; end
      4'b0101:          begin op_x = in_a; op_y = in_b;  cin = fc;   end
      4'b0110:          begin op_x = in_a; op_y = ~in_b; cin = fc;   end
      4'b0111:          begin op_x = in_b; op_y = ~in_a; cin = fc;   end
      default:          arith = 1'b0;
    endcase
    sum = {1'b0, op_x} + {1'b0, op_y} + {{DATAWIDTH{1'b0}}, cin};
    case (in_op)
      4'b0000, 4'b1000: alu_res = in_a & in_b;
      4'b0001, 4'b1001: alu_res = in_a ^ in_b;
      4'b1100:          alu_res = in_a | in_b;
      4'b1101:          alu_res = in_a;
      4'b1110:          alu_res = in_a & ~in_b;
      4'b1111:          alu_res = ~in_b;
      default:          alu_res = sum[DATAWIDTH-1:0];
    endcase
    alu_c = arith ? sum[DATAWIDTH] : fc;
    alu_v = arith ? ((op_x[DATAWIDTH-1] == op_y[DATAWIDTH-1]) &&
                     (sum[DATAWIDTH-1] != op_x[DATAWIDTH-1])) : fv;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && in_mul && cond_pass) state_next = MUL;
      MUL:     if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A result loading on the same edge as a consume overrides the clear below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_wr       <= 1'b0;
      out_executed <= 1'b0;
      flags        <= 4'b0000;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      cnt          <= '0;
      mul_s        <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (!cond_pass) begin
          out_valid    <= 1'b1;
          out_result   <= '0;
          out_wr       <= 1'b0;
          out_executed <= 1'b0;
        end else if (in_mul) begin
          acc    <= in_acc ? in_c : '0;
          mcand  <= in_a;
          mplier <= in_b;
          cnt    <= '0;
          mul_s  <= in_set_flags;
        end else begin
          out_valid    <= 1'b1;
          out_result   <= alu_res;
          out_wr       <= ~is_test;
          out_executed <= 1'b1;
          if (is_test || in_set_flags)
            flags <= {alu_res[DATAWIDTH-1], (alu_res == '0), alu_c, alu_v};
        end
      end else if (state == MUL) begin
        if (!mul_full) begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end else if (mul_done) begin
          out_valid    <= 1'b1;
          out_result   <= acc;
          out_wr       <= 1'b1;
          out_executed <= 1'b1;
          if (mul_s) flags <= {acc[DATAWIDTH-1], (acc == '0), fc, fv};
        end
      end
    end
  end

endmodule

// File: tb/tb_arm_alu_seq.sv
// Directed + randomized bench for arm_alu_seq, checked against an arithmetic
// reference model of ARM data-processing and multiply semantics.
module tb_arm_alu_seq;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, in_mul, in_acc, in_set_flags;
  logic [3:0]    in_op, in_cond;
  logic [DW-1:0] in_a, in_b, in_c;
  logic          out_valid, out_ready, out_wr, out_executed;
  logic [DW-1:0] out_result;
  logic [3:0]    flags_nzcv;

  int            checks = 0;
  int            errors = 0;
  logic [3:0]    m_flags;
  logic [31:0]   e_res;
  logic          e_wr, e_exec;

  arm_alu_seq #(.DATAWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_mul(in_mul),
    .in_acc(in_acc), .in_set_flags(in_set_flags), .in_cond(in_cond),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_wr(out_wr), .out_executed(out_executed), .flags_nzcv(flags_nzcv)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: condition table, then plain integer arithmetic on the operands.
  task automatic ref_model(input logic [3:0] op, input logic mul, input logic acc,
                           input logic s, input logic [3:0] cond,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    bit n, z, cf, v, pass, sub, arith, test, nc, nv;
    longint x, y, k, u, sx, sy, sr;
    longint unsigned p;
    logic [31:0] res;
    n = m_flags[3]; z = m_flags[2]; cf = m_flags[1]; v = m_flags[0];
    case (cond)
      4'h0: pass = z;        4'h1: pass = !z;
      4'h2: pass = cf;       4'h3: pass = !cf;
      4'h4: pass = n;        4'h5: pass = !n;
      4'h6: pass = v;        4'h7: pass = !v;
      4'h8: pass = cf && !z; 4'h9: pass = !cf || z;
      4'hA: pass = (n == v); 4'hB: pass = (n != v);
      4'hC: pass = !z && (n == v);
      4'hD: pass = z || (n != v);
      default: pass = 1'b1;
    endcase
    e_exec = pass;
    if (!pass) begin
      e_res = 32'h0; e_wr = 1'b0;
      return;
    end
    if (mul) begin
      p = longint'({32'h0, a}) * longint'({32'h0, b}) + (acc ? longint'({32'h0, c}) : 64'd0);
      e_res = p[31:0];
      e_wr  = 1'b1;
      if (s) m_flags = {e_res[31], e_res == 32'h0, cf, v};
      return;
    end
    arith = 1'b1; sub = 1'b0; x = 0; y = 0; k = 0;
    case (op)
      4'b0010, 4'b1010: begin sub = 1; x = {32'h0, a}; y = {32'h0, b}; k = 0; end
      4'b0011:          begin sub = 1; x = {32'h0, b}; y = {32'h0, a}; k = 0; end
      4'b0100, 4'b1011: begin sub = 0; x = {32'h0, a}; y = {32'h0, b}; k = 0; end
      4'b0101:          begin sub = 0; x = {32'h0, a}; y = {32'h0, b}; k = cf; end
      4'b0110:          begin sub = 1; x = {32'h0, a}; y = {32'h0, b}; k = !cf; end
      4'b0111:          begin sub = 1; x = {32'h0, b}; y = {32'h0, a}; k = !cf; end
      default:          arith = 1'b0;
    endcase
    if (arith) begin
      sx = (x >= 64'sh80000000) ? x - 64'sh100000000 : x;
      sy = (y >= 64'sh80000000) ? y - 64'sh100000000 : y;
      u  = sub ? x - y - k : x + y + k;
      sr = sub ? sx - sy - k : sx + sy + k;
      res = u[31:0];
      nc  = sub ? (u >= 0) : (u > 64'shFFFFFFFF);
      nv  = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
    end else begin
      case (op)
        4'b0000, 4'b1000: res = a & b;
        4'b0001, 4'b1001: res = a ^ b;
        4'b1100:          res = a | b;
        4'b1101:          res = a;
        4'b1110:          res = a & ~b;
        default:          res = ~b;
      endcase
      nc = cf; nv = v;
    end
    test  = (op >= 4'b1000) && (op <= 4'b1011);
    e_res = res;
    e_wr  = !test;
    if (test || s) m_flags = {res[31], res == 32'h0, nc, nv};
  endtask

  // Called just after a falling edge; returns at the falling edge after acceptance.
  task automatic apply_stimulus(input logic [3:0] op, input logic mul, input logic acc,
                                input logic s, input logic [3:0] cond,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    int guard = 0;
    in_op = op; in_mul = mul; in_acc = acc; in_set_flags = s; in_cond = cond;
    in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("accept_timeout", 32'(guard < 200), 32'd1);
    ref_model(op, mul, acc, s, cond, a, b, c);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_eq("result_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic check_output(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_result"}, out_result, e_res);
    check_eq({tag, "_wr"}, 32'(out_wr), 32'(e_wr));
    check_eq({tag, "_exec"}, 32'(out_executed), 32'(e_exec));
    check_eq({tag, "_nzcv"}, 32'(flags_nzcv), 32'(m_flags));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    bit busy_ok, seen;
    logic [3:0] r_op, r_cond;
    logic r_mul, r_acc, r_s;
    in_valid = 1'b0; in_op = '0; in_mul = 1'b0; in_acc = 1'b0; in_set_flags = 1'b0;
    in_cond = 4'hE; in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b1;
    m_flags = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset state");
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", out_result, 32'h0);
    check_eq("rst_wr", 32'(out_wr), 32'd0);
    check_eq("rst_exec", 32'(out_executed), 32'd0);
    check_eq("rst_nzcv", 32'(flags_nzcv), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);

    $display("[TB] add overflow");
    apply_stimulus(4'b0100, 0, 0, 1, 4'hE, 32'h7FFF_FFFF, 32'h1, 32'h0);
    check_output("add_ovf");
    check_eq("add_ovf_const", out_result, 32'h8000_0000);
    check_eq("add_ovf_nzcv_const", 32'(flags_nzcv), 32'b1001);

    $display("[TB] sub then adc back-to-back");
    apply_stimulus(4'b0010, 0, 0, 1, 4'hE, 32'd5, 32'd5, 32'h0);
    check_output("sub_zero");
    check_eq("sub_zero_nzcv_const", 32'(flags_nzcv), 32'b0110);
    check_eq("b2b_ready", 32'(in_ready), 32'd1);
    apply_stimulus(4'b0101, 0, 0, 0, 4'hE, 32'd1, 32'd1, 32'h0);
    check_output("adc");
    check_eq("adc_const", out_result, 32'd3);

    $display("[TB] compare and conditions");
    apply_stimulus(4'b1010, 0, 0, 0, 4'hE, 32'd3, 32'd7, 32'h0);
    check_output("cmp");
    check_eq("cmp_nzcv_const", 32'(flags_nzcv), 32'b1000);
    apply_stimulus(4'b1101, 0, 0, 0, 4'h0, 32'd9, 32'd0, 32'h0);
    check_output("mov_eq_fail");
    check_eq("mov_eq_exec_const", 32'(out_executed), 32'd0);
    apply_stimulus(4'b1101, 0, 0, 0, 4'hB, 32'd9, 32'd0, 32'h0);
    check_output("mov_lt");
    check_eq("mov_lt_const", out_result, 32'd9);

    $display("[TB] multiply-accumulate");
    apply_stimulus(4'b0000, 1, 1, 1, 4'hE, 32'h0001_0001, 32'h0001_0001, 32'd5);
    wait_result(lat, busy_ok);
    check_eq("mla_latency", 32'(lat), 32'd33);
    check_eq("mla_busy", 32'(busy_ok), 32'd1);
    check_output("mla");
    check_eq("mla_const", out_result, 32'h0002_0006);

    $display("[TB] backpressure");
    apply_stimulus(4'b0100, 0, 0, 0, 4'hE, 32'd2, 32'd3, 32'h0);
    out_ready = 1'b0;
    in_op = 4'b0001; in_mul = 1'b0; in_set_flags = 1'b1; in_cond = 4'hE;
    in_a = 32'hF0F0_0000; in_b = 32'h0FF0_0000; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_hold_result", out_result, 32'd5);
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_no_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    apply_stimulus(4'b0001, 0, 0, 1, 4'hE, 32'hF0F0_0000, 32'h0FF0_0000, 32'h0);
    check_output("bp_queued_eor");

    $display("[TB] randomized ops");
    for (int i = 0; i < 40; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_mul = ($urandom_range(0, 4) == 0);
      r_acc = 1'($urandom_range(0, 1));
      r_s = 1'($urandom_range(0, 1));
      r_cond = 4'($urandom_range(0, 15));
      apply_stimulus(r_op, r_mul, r_acc, r_s, r_cond, pick_operand(), pick_operand(), pick_operand());
      wait_result(lat, busy_ok);
      check_eq("rand_latency", 32'(lat), (r_mul && e_exec) ? 32'd33 : 32'd0);
      check_output("rand");
    end

    $display("[TB] reset during multiply");
    apply_stimulus(4'b0000, 1, 0, 1, 4'hE, $urandom, $urandom, 32'h0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_flags = 4'b0000;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_nzcv", 32'(flags_nzcv), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("midrst_no_stale", 32'(seen), 32'd0);
    check_eq("midrst_ready", 32'(in_ready), 32'd1);
    apply_stimulus(4'b0100, 0, 0, 1, 4'hE, 32'd1, 32'd2, 32'h0);
    check_output("post_reset_add");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_alu_seq.md
Name: arm_alu_seq

Overview:
Registered, handshaked successor to the team's combinational ARM data-path ALU. Executes all 16 ARM data-processing opcodes plus an iterative MUL/MLA, owns an internal NZCV flag register, and gates each operation on an ARM condition code. It sits between decode and register-file writeback and supports back-to-back single-cycle ops with flag forwarding.

Parameters:
DATAWIDTH, 32, operand/result width (>= 4)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_op  in  4  0000 AND,0001 EOR,0010 SUB,0011 RSB,0100 ADD,0101 ADC,0110 SBC,0111 RSC,1000 TST,1001 TEQ,1010 CMP,1011 CMN,1100 ORR,1101 MOV,1110 BIC,1111 MVN
in_mul  in  1  1 = multiply; in_op ignored
in_acc  in  1  with in_mul: MLA (add in_c)
in_set_flags  in  1  S bit
in_cond  in  4  ARM condition code
in_a, in_b, in_c  in  DATAWIDTH  operands; in_c accumulator
out_valid  out  1  result valid
out_ready  in  1  consumer accepts when out_valid & out_ready
out_result  out  DATAWIDTH  result
out_wr  out  1  result must be written back
out_executed  out  1  condition passed
flags_nzcv  out  4  current flag register {N,Z,C,V}

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_valid/out_wr/out_executed=0, out_result=0, flags_nzcv=0000, multiply counter/regs 0. Reset mid-multiply abandons it; no output produced.
- One output register. in_ready = (state==IDLE) & (~out_valid | out_ready). out_valid cleared on out_ready unless a new result loads the same edge.
- Condition evaluated at acceptance against flags_nzcv (already includes previous op's update). EQ..LE per ARM; 1110 and 1111 both always pass.
- Cond fail: result loads next edge, out_executed=0, out_wr=0, out_result=0, flags unchanged; in_mul fail also 1 cycle.
- Single-cycle ops: latency 1 (accept edge -> out_valid). Flags update on same edge as result, so next op accepted the following cycle sees them (ADC/SBC/RSC use updated C).
- Arithmetic: SUB=a+~b+1, RSB=b+~a+1, ADD=a+b, ADC=a+b+C, SBC=a+~b+C, RSC=b+~a+C, CMP as SUB, CMN as ADD. Sums DATAWIDTH+1 bits; C = bit DATAWIDTH (borrow inverted, ARM style); V = signed overflow of the two addends vs result.
- Logical: AND, EOR, ORR, MOV=in_a, BIC=a&~b, MVN=~in_b, TST as AND, TEQ as EOR. C,V unchanged.
- Flag write: TST/TEQ/CMP/CMN always update flags, out_wr=0. Others update only if in_set_flags, out_wr=1. N=msb, Z=(result==0).
- Multiply FSM: IDLE -> MUL on accept with in_mul and cond pass. Load acc=(in_acc?in_c:0), mcand=in_a, mplier=in_b, cnt=0. Each MUL cycle: if mplier[0] acc+=mcand; mcand<<=1; mplier>>=1; cnt++. After DATAWIDTH cycles load output register (low DATAWIDTH bits), return IDLE. Fixed latency DATAWIDTH+1 from accept to out_valid; in_ready=0 throughout. If in_set_flags: N,Z from result, C,V unchanged. out_wr=1.
- Backpressure: out_valid & ~out_ready holds out_result/out_wr/out_executed stable, in_ready=0. Completing multiply only enters the output register once it is free; otherwise it stays in MUL with cnt saturated.
- in_* ignored when not accepted.

Test Plan:
- Reset, ADD S a=0x7FFFFFFF b=1 -> next cycle out_valid, result 0x80000000, out_wr=1, NZCV=1001.
- SUB S a=5 b=5 (NZCV=0110), next cycle ADC a=1 b=1 -> result 3, back-to-back, no stall.
- CMP a=3 b=7 -> out_wr=0, NZCV=1000; MOV cond=EQ -> out_executed=0, result 0, flags unchanged; MOV cond=LT a=9 -> result 9.
- MLA a=0x10001 b=0x10001 c=5 -> in_ready=0 for 32 cycles, out_valid on cycle 33, result 0x00020006, S=1 gives NZ=00, CV unchanged.
- out_ready=0 for 3 cycles after valid result -> out_result stable, in_ready=0, no accept; release -> queued request accepted.
- rst_n low at multiply cycle 10 -> out_valid=0, NZCV=0000 immediately; after release in_ready=1, no stale result.
